lbp_hist: RTL

Downstream consumer of the LBP stage. Snoops the LBP result write port (`lbp_valid`/`lbp_addr`/`lbp_data`) and builds a 256-bin histogram of LBP codes over the interior pixels of the 128×128 image. On the LBP stage's `finish` pulse, it streams the 256 bin counts out over a valid/ready port, bin 0 first, then signals completion.

---
 rtl/lbp_pkg.sv | 25 ++
 rtl/hist_bank.sv | 33 +++
 rtl/lbp_hist.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, state type and address predicate for the LBP histogram
package lbp_pkg;

  localparam int IMG_W     = 128;
  localparam int CNT_W_DEF = 14;
  localparam int ADDR_W    = 14;
  localparam int NBINS     = 256;

  typedef enum logic [1:0] {
    ACCUM,
    SETTLE,
    READ,
    DONE
  } lbp_hist_state_t;

  // True when the row-major address lies off the one-pixel image border.
  function automatic logic is_interior(input logic [ADDR_W-1:0] addr);
    int row;
    int col;
    row = int'(addr) / IMG_W;
    col = int'(addr) % IMG_W;
    return (row >= 1) && (row <= IMG_W - 2) && (col >= 1) && (col <= IMG_W - 2);
  endfunction

endpackage

// File: rtl/hist_bank.sv
// rtl/hist_bank.sv - 256-bin saturating counter bank with one increment and one async read port
module hist_bank
  import lbp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  logic [7:0]       inc_idx,
  output logic             sat,
  input  logic [7:0]       rd_idx,
  output logic [CNT_W-1:0] rd_data
);

  logic [CNT_W-1:0] bins_q [NBINS];

  assign sat     = &bins_q[inc_idx];
  assign rd_data = bins_q[rd_idx];

  // Flop storage: each increment reads and writes within one cycle, so
  // back-to-back hits on the same bin all count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBINS; i++) begin
        bins_q[i] <= '0;
      end
    end else if (inc_en && !sat) begin
      bins_q[inc_idx] <= bins_q[inc_idx] + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lbp_hist.sv
// rtl/lbp_hist.sv - snoops LBP results into a 256-bin histogram and streams the bins out
module lbp_hist
  import lbp_pkg::*;
#(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            lbp_valid,
  input  logic [$clog2(IMG_W*IMG_W)-1:0]  lbp_addr,
  input  logic [7:0]                      lbp_data,
  input  logic                            lbp_finish,
  output logic                            hist_valid,
  input  logic                            hist_ready,
  output logic [7:0]                      hist_bin,
  output logic [CNT_W-1:0]                hist_data,
  output logic [CNT_W-1:0]                pix_cnt,
  output logic                            drop_err,
  output logic                            hist_done
);

  lbp_hist_state_t  state_q;
  logic             hist_valid_q;
  logic             hist_done_q;
  logic             drop_err_q;
  logic [7:0]       hist_bin_q;
  logic [7:0]       hist_bin_d;
  logic [CNT_W-1:0] hist_data_q;
  logic [CNT_W-1:0] pix_cnt_q;

  logic             interior;
  logic             inc_en;
  logic             bin_sat;
  logic             rd_accept;
  logic [CNT_W-1:0] rd_data;

  hist_bank #(.CNT_W(CNT_W)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .inc_en  (inc_en),
    .inc_idx (lbp_data),
    .sat     (bin_sat),
    .rd_idx  (hist_bin_d),
    .rd_data (rd_data)
  );

  // The bank is read at the next bin index so hist_data can be registered
  // alongside hist_bin.
  always_comb begin
    interior   = is_interior(lbp_addr);
    inc_en     = (state_q == ACCUM) && lbp_valid && interior;
    rd_accept  = (state_q == READ) && hist_valid_q && hist_ready;
    hist_bin_d = hist_bin_q;
    if (state_q == SETTLE) begin
      hist_bin_d = '0;
    end else if (rd_accept) begin
      hist_bin_d = hist_bin_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ACCUM;
      hist_valid_q <= 1'b0;
      hist_done_q  <= 1'b0;
      drop_err_q   <= 1'b0;
      hist_bin_q   <= '0;
      hist_data_q  <= '0;
      pix_cnt_q    <= '0;
    end else begin
      if (lbp_valid && (state_q != ACCUM)) begin
        drop_err_q <= 1'b1;
      end
      case (state_q)
        ACCUM: begin
          if (lbp_valid) begin
            if (interior) begin
              pix_cnt_q <= pix_cnt_q + CNT_W'(1);
              if (bin_sat) begin
                drop_err_q <= 1'b1;
              end
            end else begin
              drop_err_q <= 1'b1;
            end
          end
          if (lbp_finish) begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          state_q      <= READ;
          hist_valid_q <= 1'b1;
          hist_bin_q   <= hist_bin_d;
          hist_data_q  <= rd_data;
        end
        READ: begin
          if (rd_accept) begin
            if (hist_bin_q == 8'd255) begin
              state_q      <= DONE;
              hist_valid_q <= 1'b0;
              hist_done_q  <= 1'b1;
            end else begin
              hist_bin_q  <= hist_bin_d;
              hist_data_q <= rd_data;
            end
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign hist_valid = hist_valid_q;
  assign hist_bin   = hist_bin_q;
  assign hist_data  = hist_data_q;
  assign pix_cnt    = pix_cnt_q;
  assign drop_err   = drop_err_q;
  assign hist_done  = hist_done_q;

endmodule
